multiexp_core_dispatcher: RTL



---
 rtl/multiexp_core_dispatcher.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/multiexp_core_dispatcher.sv
//
// multiexp_core_dispatcher
//
// Job scheduler between the scalar/point read streams and a pool of G1
// point-multiply cores. A start pulse arms a run of i_num_in jobs. Each job
// is one scalar joined with one point and is issued to an idle core picked
// by the arbiter. Outstanding jobs are counted until every issued job has
// reported completion, then o_done pulses for one cycle.
//
// Build option:
//   MULTIEXP_DISPATCH_RR_EN  defined   -> round-robin core selection; the search
//                                         starts one past the last granted core
//                            undefined -> fixed priority, lowest eligible index
//                                         wins; no pointer register is built
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_start, i_num_in                run start pulse, job count sampled on start
//   i_scl_val, o_scl_rdy, i_scl_dat  scalar stream
//   i_pnt_val, o_pnt_rdy, i_pnt_dat  point stream
//   o_job_val                        one-hot issue strobe, one bit per core
//   i_job_rdy                        per-core idle level
//   o_job_dat                        {scalar, point}, bus shared by all cores
//   i_cmp_val                        per-core completion pulses
//   o_busy                           run in progress (cycle after start .. done)
//   o_done                           one-cycle run-complete pulse
//   o_err                            sticky error: stray completion or start
//                                    while a run is active
//
module multiexp_core_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int SCL_BITS  = 256,
  parameter int PNT_BITS  = 512,
  parameter int CNT_BITS  = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [CNT_BITS-1:0]          i_num_in,
  input  logic                         i_scl_val,
  output logic                         o_scl_rdy,
  input  logic [SCL_BITS-1:0]          i_scl_dat,
  input  logic                         i_pnt_val,
  output logic                         o_pnt_rdy,
  input  logic [PNT_BITS-1:0]          i_pnt_dat,
  output logic [NUM_CORES-1:0]         o_job_val,
  input  logic [NUM_CORES-1:0]         i_job_rdy,
  output logic [SCL_BITS+PNT_BITS-1:0] o_job_dat,
  input  logic [NUM_CORES-1:0]         i_cmp_val,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t               state_reg;
  logic [CNT_BITS-1:0]  remaining_reg;
  logic [CNT_BITS-1:0]  outstanding_reg;
  logic [NUM_CORES-1:0] holding_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] cmp_ok;
  logic [NUM_CORES-1:0] cmp_stray;
  logic [NUM_CORES-1:0] grant_onehot;
  logic                 fire;
  logic [CNT_BITS-1:0]  cmp_count;
  logic [CNT_BITS-1:0]  outstanding_next;

  // A core may take a job only if it reports idle and we have not already
  // handed it one that is still in flight. Completions are only honoured
  // from cores that actually hold a job; anything else is a stray pulse.
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign eligible[gi]  = i_job_rdy[gi] & ~holding_reg[gi];
      assign cmp_ok[gi]    = i_cmp_val[gi] &  holding_reg[gi];
      assign cmp_stray[gi] = i_cmp_val[gi] & ~holding_reg[gi];
    end
  endgenerate

  // Several cores may finish in the same cycle, so count all of them.
  always_comb begin
    cmp_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cmp_count = cmp_count + CNT_BITS'(cmp_ok[i]);
    end
  end

`ifdef MULTIEXP_DISPATCH_RR_EN
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Holds the index where the next search begins, i.e. one past the core
  // granted last. Resetting it to 0 makes the first grant of a fresh
  // pointer go to core 0.
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;

  // Pick the eligible core with the smallest circular distance from the
  // pointer; scanning by distance avoids variable-index wrap arithmetic.
  always_comb begin
    int best;
    int dist;
    int best_dist;
    best      = 0;
    dist      = 0;
    best_dist = NUM_CORES;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (eligible[j]) begin
        dist = j - int'(rr_ptr_reg);
        if (dist < 0) begin
          dist = dist + NUM_CORES;
        end
        if (dist < best_dist) begin
          best_dist = dist;
          best      = j;
        end
      end
    end
    grant_onehot = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if ((best_dist < NUM_CORES) && (j == best)) begin
        grant_onehot[j] = 1'b1;
      end
    end
    rr_ptr_next = (best == NUM_CORES - 1) ? '0 : IDX_W'(best + 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_reg <= '0;
    end else if (fire) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  // Fixed priority: the lowest-index eligible core wins.
  always_comb begin
    logic found;
    found        = 1'b0;
    grant_onehot = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (eligible[j] && !found) begin
        grant_onehot[j] = 1'b1;
        found           = 1'b1;
      end
    end
  end
`endif

  // Joined handshake: both streams are consumed together, and only when a
  // core is available, so neither stream can run ahead of the other.
  assign fire = (state_reg == ST_ISSUE) & i_scl_val & i_pnt_val & (|eligible);

  assign o_job_val = fire ? grant_onehot : '0;
  assign o_scl_rdy = fire;
  assign o_pnt_rdy = fire;
  assign o_job_dat = fire ? {i_scl_dat, i_pnt_dat} : '0;

  // Issue and completion in the same cycle net out here.
  assign outstanding_next = outstanding_reg + CNT_BITS'(fire) - cmp_count;

  assign o_busy = busy_reg;
  assign o_done = done_reg;
  assign o_err  = err_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= ST_IDLE;
      remaining_reg   <= '0;
      outstanding_reg <= '0;
      holding_reg     <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      holding_reg     <= (holding_reg & ~cmp_ok) | o_job_val;
      outstanding_reg <= outstanding_next;
      done_reg        <= 1'b0;

      // An accepted start clears the flag, but a stray completion in the
      // very same cycle still wins.
      if ((|cmp_stray) || (i_start && (state_reg != ST_IDLE))) begin
        err_reg <= 1'b1;
      end else if (i_start) begin
        err_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            remaining_reg   <= i_num_in;
            outstanding_reg <= '0;
            busy_reg        <= 1'b1;
            if (i_num_in == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (fire) begin
            remaining_reg <= remaining_reg - CNT_BITS'(1);
            if (remaining_reg == CNT_BITS'(1)) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding_next == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
